div_arbiter: RTL
================

# div_arbiter

Shares one fixed-point `div` instance between `NUM_REQ` requesters. It grants requesters round-robin, latches the winner's operands, and sequences the divider's start/ready/complete handshake. It then returns the quotient and divide-by-zero flag to the granted requester over a valid/ready response channel. It sits between the navigation math clients and the single divider, so those clients never drive `div` directly.

## Interface
- `DATA_WIDTH`, 32: operand and quotient width; passed to `div` as `DATA_WIDTH`.
- `BIN_POS`, 16: binary point position (fraction bits); passed to `div` as `BIN_POS`.
- `NUM_REQ`, 4: number of requesters; 2..16.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `req_valid` input NUM_REQ: requester i has operands pending.
- `req_ready` output NUM_REQ: one-hot accept; transfer when `req_valid[i] && req_ready[i]`.
- `req_num` input NUM_REQ*DATA_WIDTH: flat numerators, slice i at [i*DATA_WIDTH +: DATA_WIDTH].
- `req_denom` input NUM_REQ*DATA_WIDTH: flat denominators, same slicing.
- `resp_valid` output NUM_REQ: one-hot result valid for the granted requester.
- `resp_ready` input NUM_REQ: requester i accepts the result.
- `resp_quot` output DATA_WIDTH: quotient, shared bus, meaningful only while any `resp_valid`.
- `resp_div_zero` output 1: divide-by-zero flag, qualified like `resp_quot`.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT_DONE, RESP.
- IDLE: if any `req_valid`, select winner g by round-robin starting at pointer `ptr`. Assert `req_ready[g]` for that one cycle, latch num/denom into operand registers, go to START.
- START: drive divider `rst` high with latched operands. Hold until divider `ready` is sampled high, then deassert and go to WAIT_DONE.
- WAIT_DONE: wait for divider `complete` with divider `rst` low. Capture `quot` and `div_zero` into output registers, go to RESP.
- RESP: assert `resp_valid[g]` with registered result. On `resp_ready[g]`, set `ptr = (g+1) mod NUM_REQ` and go to IDLE.
- At most one request is in flight; all other `req_ready` bits stay low while `busy`.
- The result is held stable through backpressure; no new grant is made until the response transfers.
- `req_valid` dropping after grant has no effect; the operands are already latched.
- The divider's own `rst` is `rst | start_pulse`. Global reset always resets the divider.
- Arithmetic: signed two's-complement fixed point Q(DATA_WIDTH-BIN_POS).BIN_POS. The quotient is exactly the divider's output; no rounding or saturation is added here.

## Timing
- Reset values: `req_ready` 0, `resp_valid` 0, `resp_quot` 0, `resp_div_zero` 0, `busy` 0, `ptr` 0, state IDLE.
- Grant: `req_ready[g]` is combinational from IDLE and `req_valid`, so acceptance occurs in the first IDLE cycle with a valid request.
- Latency from accept to `resp_valid` is 2 cycles plus divider latency (ready wait plus compute).
- Back-to-back: with `resp_ready` held high, the next grant comes 1 cycle after the response transfers (the RESP->IDLE cycle).
- Reset asserted mid-operation aborts the transfer immediately. The result is lost, all outputs return to reset values, and the requester must re-request.
- When `req_valid` and a completing response to the same requester coincide, the response transfers first. The new request is granted in the following IDLE cycle.

## Configuration
- `DIV_ARB_ZERO_BYPASS_EN` defined: in IDLE, if the winner's denominator is 0, skip START/WAIT_DONE. Go directly to RESP with `resp_div_zero`=1 and `resp_quot`=0; the divider is never started. Latency is 1 cycle after accept.
- Undefined: zero denominators go through the divider like any other request, and `resp_div_zero`/`resp_quot` are whatever `div` reports.

## Structure
- Package `div_arb_pkg`: state enum (IDLE, START, WAIT_DONE, RESP), a function to extract an operand slice, and the default width constants.
- Sub-module `rr_arbiter`: NUM_REQ-wide round-robin selector. Inputs are request vector and pointer; outputs are one-hot grant and index. Purely combinational.
- The top level contains the FSM, operand/result registers and the `div` instance.

## Test plan
- 6.0/2.0, requester 1 only: num 0x00060000, denom 0x00020000 -> one `req_ready[1]` pulse, then `resp_valid[1]` with `resp_quot` 0x00030000 and `resp_div_zero` 0.
- Fractional: 1.5/0.5 (0x00018000/0x00008000) -> 0x00030000. Negative: -4.0/2.0 (0xFFFC0000/0x00020000) -> 0xFFFE0000.
- All 4 requesters valid continuously with `ptr`=0: grant order 0,1,2,3,0, and each `req_ready` bit pulses only once per grant.
- Backpressure: `resp_ready` held low 5 cycles -> `resp_valid` and `resp_quot` stable, `req_ready` all 0, no new grant; the transfer occurs on the 6th cycle.
- Denominator 0: with the macro, `resp_div_zero`=1 and `resp_quot`=0 one cycle after accept, and divider `rst` never pulses. Without the macro, `resp_div_zero`=1 is reported via the divider.
- Reset asserted during WAIT_DONE -> all outputs at reset values in the same cycle, and the next request is granted starting at index 0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter.
package div_arb_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefBinPos    = 16;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxNumReq    = 16;
  localparam int unsigned MaxFlatWidth = MaxDataWidth * MaxNumReq;

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StResp} arb_state_e;

  // Returns slice idx of a flat bus; the caller truncates to the real width.
  function automatic logic [MaxDataWidth-1:0] op_slice(input logic [MaxFlatWidth-1:0] flat,
                                                       input int unsigned idx,
                                                       input int unsigned width);
    logic [MaxFlatWidth-1:0] sh;
    sh = flat >> (idx * width);
    return sh[MaxDataWidth-1:0];
  endfunction

endpackage

// File: rtl/div.sv
// Sequential signed fixed-point divider: loads operands on the first cycle out of reset,
// then produces one quotient bit per cycle and holds complete until reset again.
module div #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BIN_POS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic                  ready,
  output logic                  complete,
  output logic [DATA_WIDTH-1:0] quot,
  output logic                  div_zero
);

  localparam int unsigned QW   = DATA_WIDTH + BIN_POS;
  localparam int unsigned CntW = $clog2(QW + 1);

  logic                  ready_q, run_q, done_q, neg_q, zero_q;
  logic [DATA_WIDTH-1:0] rem_q, dsr_q, rem_d, num_mag, den_mag;
  logic [QW-1:0]         dvd_q, dvd_d;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH:0]   rem_sh;

  assign num_mag = num[DATA_WIDTH-1] ? (~num + 1'b1) : num;
  assign den_mag = denom[DATA_WIDTH-1] ? (~denom + 1'b1) : denom;

  // Restoring step: dvd_q doubles as the quotient shift register.
  always_comb begin
    rem_sh = {rem_q, dvd_q[QW-1]};
    dvd_d  = {dvd_q[QW-2:0], 1'b0};
    rem_d  = rem_sh[DATA_WIDTH-1:0];
    if (rem_sh >= {1'b0, dsr_q}) begin
      rem_d    = DATA_WIDTH'(rem_sh - {1'b0, dsr_q});
      dvd_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      cnt_q   <= '0;
    end else if (ready_q) begin
      ready_q <= 1'b0;
      run_q   <= 1'b1;
      neg_q   <= num[DATA_WIDTH-1] ^ denom[DATA_WIDTH-1];
      zero_q  <= (denom == '0);
      rem_q   <= '0;
      dsr_q   <= den_mag;
      dvd_q   <= {num_mag, {BIN_POS{1'b0}}};
      cnt_q   <= CntW'(QW);
    end else if (run_q) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign ready    = ready_q;
  assign complete = done_q;
  assign div_zero = zero_q;
  assign quot     = zero_q ? '0 :
                    neg_q  ? (~dvd_q[DATA_WIDTH-1:0] + 1'b1) : dvd_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned j;
    logic        found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one div instance between NUM_REQ requesters with round-robin grants.
// Optional DIV_ARB_ZERO_BYPASS_EN answers zero-denominator requests without the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned BIN_POS    = DefBinPos,
  parameter int unsigned NUM_REQ    = DefNumReq
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_num,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_denom,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_quot,
  output logic                          resp_div_zero,
  output logic                          busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d, gidx_q, gidx_d, win_idx;
  logic [NUM_REQ-1:0]    win_gnt;
  logic [DATA_WIDTH-1:0] num_q, num_d, denom_q, denom_d, quot_q, quot_d, win_num, win_denom;
  logic                  dz_q, dz_d;
  logic                  div_rst, div_ready, div_complete, div_dz;
  logic [DATA_WIDTH-1:0] div_quot;
  logic [MaxFlatWidth-1:0] num_flat, denom_flat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign num_flat   = MaxFlatWidth'(req_num);
  assign denom_flat = MaxFlatWidth'(req_denom);
  assign win_num    = DATA_WIDTH'(op_slice(num_flat, 32'(win_idx), DATA_WIDTH));
  assign win_denom  = DATA_WIDTH'(op_slice(denom_flat, 32'(win_idx), DATA_WIDTH));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    num_d      = num_q;
    denom_d    = denom_q;
    quot_d     = quot_q;
    dz_d       = dz_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      StIdle: begin
        // Gate with rst so the combinational grant is also quiet during reset.
        if (!rst && (|req_valid)) begin
          req_ready = win_gnt;
          gidx_d    = win_idx;
          num_d     = win_num;
          denom_d   = win_denom;
          state_d   = StStart;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (win_denom == '0) begin
            quot_d  = '0;
            dz_d    = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StStart: begin
        if (div_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (div_complete) begin
          quot_d  = div_quot;
          dz_d    = div_dz;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid[gidx_q] = 1'b1;
        if (resp_ready[gidx_q]) begin
          ptr_d   = IdxW'((32'(gidx_q) + 1) % NUM_REQ);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      num_q   <= '0;
      denom_q <= '0;
      quot_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      num_q   <= num_d;
      denom_q <= denom_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
    end
  end

  assign div_rst       = rst | (state_q == StStart);
  assign busy          = (state_q != StIdle);
  assign resp_quot     = quot_q;
  assign resp_div_zero = dz_q;

  div #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIN_POS    (BIN_POS)
  ) u_div (
    .clk      (clk),
    .rst      (div_rst),
    .num      (num_q),
    .denom    (denom_q),
    .ready    (div_ready),
    .complete (div_complete),
    .quot     (div_quot),
    .div_zero (div_dz)
  );

endmodule
